// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Shared datapath widths, register IDs and write-back select encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

    // Link takes precedence over MemtoReg (jal/jalr never load).
    function automatic wb_sel_e wb_sel_decode(input logic link, input logic memtoreg);
        if (link) begin
            return WB_SEL_LINK;
        end else if (memtoreg) begin
            return WB_SEL_MEM;
        end
        return WB_SEL_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// ============================================================================
// Module : mem_wb_reg
// MEM/WB flop bank with flush-over-stall priority and asynchronous reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic                  i_regwrite,
    input  logic [REG_ADDR_W-1:0] i_dest,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_valid,
    output logic                  o_regwrite,
    output logic [REG_ADDR_W-1:0] o_dest,
    output logic [DATA_W-1:0]     o_data
);

    logic                  r_valid;
    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0]     r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_dest     <= '0;
            r_data     <= '0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_dest     <= '0;
            r_data     <= '0;
        end else if (!i_stall) begin
            r_valid    <= i_valid;
            r_regwrite <= i_regwrite;
            r_dest     <= i_dest;
            r_data     <= i_data;
        end
    end

    assign o_valid    = r_valid;
    assign o_regwrite = r_regwrite;
    assign o_dest     = r_dest;
    assign o_data     = r_data;

endmodule

`default_nettype wire

// File: rtl/write_back_stage.sv
// ============================================================================
// Module : write_back_stage
// MEM/WB register, write-back data select, $zero suppression, retire counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_back_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = mips_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_mem,
    input  logic                  RegWrite_mem,
    input  logic                  MemtoReg_mem,
    input  logic                  Link_mem,
    input  logic [REG_ADDR_W-1:0] dest_mem,
    input  logic [DATA_W-1:0]     alu_result_mem,
    input  logic [DATA_W-1:0]     read_data_mem,
    input  logic [DATA_W-1:0]     pc_plus8_mem,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegisterID,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  wb_valid,
    output logic [CNT_W-1:0]      retired_count
);

    wb_sel_e               w_sel;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_wb_valid;
    logic                  w_wb_regwrite;
    logic [REG_ADDR_W-1:0] w_wb_dest;
    logic [DATA_W-1:0]     w_wb_data;
    logic                  w_retire;
    logic [CNT_W-1:0]      r_retired;

    // Select before the register so WriteData leaves straight from a flop.
    always_comb begin
        w_sel      = wb_sel_decode(Link_mem, MemtoReg_mem);
        w_sel_data = alu_result_mem;
        case (w_sel)
            WB_SEL_MEM:  w_sel_data = read_data_mem;
            WB_SEL_LINK: w_sel_data = pc_plus8_mem;
            default:     w_sel_data = alu_result_mem;
        endcase
    end

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_stall    (stall_i),
        .i_flush    (flush_i),
        .i_valid    (valid_mem),
        .i_regwrite (RegWrite_mem),
        .i_dest     (dest_mem),
        .i_data     (w_sel_data),
        .o_valid    (w_wb_valid),
        .o_regwrite (w_wb_regwrite),
        .o_dest     (w_wb_dest),
        .o_data     (w_wb_data)
    );

    assign w_retire = valid_mem & ~stall_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign RegWrite        = w_wb_valid & w_wb_regwrite &
                             (w_wb_dest != REG_ADDR_W'(REG_ZERO));
    assign WriteRegisterID = w_wb_dest;
    assign WriteData       = w_wb_data;
    assign wb_valid        = w_wb_valid;
    assign retired_count   = r_retired;

endmodule

`default_nettype wire
